xbar_wt_loader: RTL and testbench
=================================

// Module: xbar_wt_loader
// PURPOSE
//  Upstream feeder of the crossbar weight memory. Collects one full crossbar weight image
//  row-by-row over a valid/ready stream into an internal staging buffer. Then issues a
//  single-cycle prog_wt with the complete image on wr_weight, so the memory is updated
//  atomically. Row r, column k lands at flat index r*XBAR_SIZE+k, which matches the memory's
//  read mapping rd_addr*xbar_size+k.
// PARAMETERS
//  XBAR_SIZE  `xbar_size  crossbar rows = columns; beats per image
//  WT_BITS    `wt_bits    bits per weight
// PORTS
//  clk         in   1                        clock, all logic on posedge
//  reset       in   1                        synchronous, active-high
//  load_start  in   1                        pulse: begin collecting a new image
//  load_abort  in   1                        pulse: drop current load, no programming
//  in_valid    in   1                        in_row holds a valid row
//  in_ready    out  1                        loader accepts a row this cycle
//  in_row      in   XBAR_SIZE*WT_BITS        one row; column k at bits [k*WT_BITS +: WT_BITS]
//  busy        out  1                        high in LOAD or PROG
//  prog_wt     out  1                        one-cycle write strobe to weight memory
//  wr_weight   out  XBAR_SIZE*XBAR_SIZE x WT_BITS  unpacked image, index r*XBAR_SIZE+k
//  done        out  1                        one-cycle pulse, the cycle after prog_wt
// BEHAVIOUR
//  - Reset: state=IDLE, row_cnt=0, staging buffer all 0, in_ready=0, busy=0, prog_wt=0, done=0.
//  - FSM states: IDLE, LOAD, PROG.
//  - IDLE: in_ready=0. load_start -> LOAD, row_cnt<=0.
//  - LOAD: in_ready=1, combinational from state only; no dependence on in_valid.
//    - On in_valid&&in_ready: buffer[row_cnt*XBAR_SIZE+k] <= in_row[k], k=0..XBAR_SIZE-1; row_cnt++.
//    - Acceptance of row XBAR_SIZE-1 -> PROG.
//    - row_cnt width is $clog2(XBAR_SIZE) (min 1). No wrap is visible, because the last row
//      always exits LOAD.
//  - PROG: exactly one cycle. prog_wt=1, in_ready=0, then -> IDLE. done=1 in the following
//    cycle (registered).
//  - wr_weight is driven directly from the staging buffer in every state. It is stable during
//    PROG and holds its value afterwards. Rows not reloaded keep their old values.
//  - Latency: load_start at cycle T, with in_valid held high from T+1 -> rows accepted
//    T+1..T+XBAR_SIZE, prog_wt at T+XBAR_SIZE+1, done at T+XBAR_SIZE+2.
//  - load_start while busy: ignored.
//  - load_abort in LOAD -> IDLE, row_cnt<=0, no prog_wt, no done.
//    - Rows already written stay in the buffer.
//    - A beat presented in the same cycle is NOT captured; abort wins.
//  - load_abort in IDLE or PROG: ignored. PROG always completes.
//  - Simultaneous load_start and load_abort in IDLE: start wins -> LOAD.
//  - Reset mid-load or in PROG: immediate return to reset values. prog_wt is never asserted
//    in the reset cycle.
//  - in_valid outside LOAD: no effect; in_ready=0.
// CONFIGURATION
//  - WT_LOAD_CHECKSUM_EN defined: adds output port wt_checksum [15:0].
//    - Cleared to 0 on accepted load_start and on reset.
//    - On each accepted row, adds the zero-extended sum of that row's XBAR_SIZE weights,
//      mod 2^16.
//    - Holds its value from PROG onward until the next load_start. Abort does not clear it.
//  - WT_LOAD_CHECKSUM_EN undefined: port and logic absent. All other behaviour identical.
// TESTING  (XBAR_SIZE=4, WT_BITS=8)
//  - Reset, then idle 5 cycles -> in_ready=0, busy=0, prog_wt=0, done=0, all wr_weight=0.
//  - load_start; rows {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15} with in_valid held high
//    -> wr_weight[i]=i. prog_wt high exactly 1 cycle, 5 cycles after load_start. done 1 cycle
//    later.
//  - Same load with in_valid toggling 1,0,1,0... -> identical image. prog_wt only after the
//    4th accepted row.
//  - Load of all-0xAA. Then load_start, 2 rows of 0x55, load_abort asserted together with a
//    3rd valid row -> no prog_wt, busy=0. Buffer rows 0-1=0x55, rows 2-3=0xAA.
//  - Reset asserted after row 2 of a load -> no prog_wt, busy=0, wr_weight all 0. A new load
//    then completes normally.
//  - WT_LOAD_CHECKSUM_EN build, image from scenario 2 -> wt_checksum=120 (0x0078) at prog_wt.
//    All-0xFF image -> 16*255=4080 (0x0FF0).

Source files
------------

// File: rtl/xbar_wt_loader_if.sv
// xbar_wt_loader_if: valid/ready row stream feeding the crossbar weight loader
interface xbar_wt_loader_if #(
   parameter int XBAR_SIZE = 4,
   parameter int WT_BITS = 8
);
   logic in_valid;
   logic in_ready;
   logic [XBAR_SIZE*WT_BITS-1:0] in_row;
   modport master (output in_valid, output in_row, input in_ready);
   modport slave (input in_valid, input in_row, output in_ready);
endinterface

// File: rtl/xbar_wt_loader.sv
// xbar_wt_loader: stages a crossbar weight image row by row, then programs it with one prog_wt strobe
// Optional WT_LOAD_CHECKSUM_EN adds a 16-bit running checksum output wt_checksum.
module xbar_wt_loader #(
   parameter int XBAR_SIZE = 4,
   parameter int WT_BITS = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic load_start,
   input  logic load_abort,
   xbar_wt_loader_if.slave in_if,
   output logic busy,
   output logic prog_wt,
   output logic done,
   output logic [WT_BITS-1:0] wr_weight [XBAR_SIZE*XBAR_SIZE]
`ifdef WT_LOAD_CHECKSUM_EN
   ,
   output logic [15:0] wt_checksum
`endif
);
   localparam int ROW_W = XBAR_SIZE * WT_BITS;
   localparam int CW = XBAR_SIZE > 1 ? $clog2(XBAR_SIZE) : 1;
   typedef enum logic [1:0] {IDLE, LOAD, PROG} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] row_cnt;
   logic [XBAR_SIZE*ROW_W-1:0] stage_q;
   logic accept, last_row;
   assign in_if.in_ready = state == LOAD;
   assign busy = state != IDLE;
   assign prog_wt = state == PROG && !reset;
   // abort outranks a beat presented in the same cycle
   assign accept = state == LOAD && in_if.in_valid && !load_abort;
   assign last_row = row_cnt == CW'(XBAR_SIZE - 1);
   always_comb begin
      state_nxt = state == IDLE ? (load_start ? LOAD : IDLE) :
                  state == LOAD ? (load_abort ? IDLE : (accept && last_row) ? PROG : LOAD) :
                  IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         row_cnt <= '0;
         stage_q <= '0;
         done <= 1'b0;
      end else begin
         state <= state_nxt;
         row_cnt <= state_nxt != LOAD ? '0 : accept ? row_cnt + 1'b1 : row_cnt;
         done <= prog_wt;
         if (accept) stage_q[row_cnt*ROW_W +: ROW_W] <= in_if.in_row;
      end
   end
   // row r occupies a contiguous slice, so flat index r*XBAR_SIZE+k maps straight through
   for (genvar i = 0; i < XBAR_SIZE*XBAR_SIZE; i++) begin : g_out
      assign wr_weight[i] = stage_q[i*WT_BITS +: WT_BITS];
   end
`ifdef WT_LOAD_CHECKSUM_EN
   logic [15:0] row_sum;
   always_comb begin
      row_sum = '0;
      for (int k = 0; k < XBAR_SIZE; k++) row_sum = row_sum + 16'(in_if.in_row[k*WT_BITS +: WT_BITS]);
   end
   always_ff @(posedge clk) begin
      if (reset || (state == IDLE && load_start)) wt_checksum <= '0;
      else if (accept) wt_checksum <= wt_checksum + row_sum;
   end
`endif
endmodule

// File: tb/tb_xbar_wt_loader.sv
// tb_xbar_wt_loader: randomized self-checking bench against an array-based image model
module tb_xbar_wt_loader;
   localparam int N = 4;
   localparam int W = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic load_start = 1'b0;
   logic load_abort = 1'b0;
   logic busy, prog_wt, done;
   logic [W-1:0] wr_weight [N*N];
`ifdef WT_LOAD_CHECKSUM_EN
   logic [15:0] wt_checksum;
`endif
   int checks = 0;
   int errors = 0;
   logic [W-1:0] model_img [N*N];
   int model_sum = 0;
   int rc = 0;
   logic [N*W-1:0] rows [N];
   xbar_wt_loader_if #(.XBAR_SIZE(N), .WT_BITS(W)) bus ();
   xbar_wt_loader #(.XBAR_SIZE(N), .WT_BITS(W)) dut (
      .clk(clk),
      .reset(reset),
      .load_start(load_start),
      .load_abort(load_abort),
      .in_if(bus),
      .busy(busy),
      .prog_wt(prog_wt),
      .done(done),
      .wr_weight(wr_weight)
`ifdef WT_LOAD_CHECKSUM_EN
      ,
      .wt_checksum(wt_checksum)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check_img(input string tag);
      for (int i = 0; i < N*N; i++) check($sformatf("%s[%0d]", tag, i), 32'(wr_weight[i]), 32'(model_img[i]));
   endtask
   task automatic check_sum(input string tag);
`ifdef WT_LOAD_CHECKSUM_EN
      check(tag, 32'(wt_checksum), 32'(model_sum[15:0]));
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask
   task automatic clear_model();
      for (int i = 0; i < N*N; i++) model_img[i] = '0;
      model_sum = 0;
      rc = 0;
   endtask
   task automatic start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      model_sum = 0;
      rc = 0;
      check("start_busy", 32'(busy), 1);
      check("start_ready", 32'(bus.in_ready), 1);
   endtask
   task automatic send_row(input logic [N*W-1:0] row, input int gaps, input bit noise);
      for (int g = 0; g < gaps; g++) begin
         bus.in_valid = 1'b0;
         bus.in_row = $urandom;
         load_start = noise;
         tick();
         check("gap_ready", 32'(bus.in_ready), 1);
         check("gap_prog", 32'(prog_wt), 0);
      end
      load_start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_row = row;
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         model_img[rc*N+k] = row[k*W +: W];
         model_sum += int'(row[k*W +: W]);
      end
      rc++;
   endtask
   task automatic finish_check();
      check("prog_hi", 32'(prog_wt), 1);
      check("prog_ready", 32'(bus.in_ready), 0);
      check("prog_busy", 32'(busy), 1);
      check("prog_done", 32'(done), 0);
      check_img("img");
      check_sum("csum_prog");
      tick();
      check("post_prog", 32'(prog_wt), 0);
      check("done_hi", 32'(done), 1);
      check("post_busy", 32'(busy), 0);
      check_sum("csum_hold");
      tick();
      check("done_lo", 32'(done), 0);
   endtask
   // gap_mode: 0 valid held high, 1 toggling, 2 random gaps
   task automatic full_load(input int gap_mode, input bit noise);
      start();
      for (int r = 0; r < N; r++) begin
         send_row(rows[r], gap_mode == 0 ? 0 : gap_mode == 1 ? (r > 0 ? 1 : 0) : int'($urandom_range(0, 3)), noise);
         if (r < N-1) check("mid_prog", 32'(prog_wt), 0);
      end
      finish_check();
   endtask
   task automatic fill_rows(input logic [W-1:0] v, input bit rnd);
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) rows[r][k*W +: W] = rnd ? W'($urandom) : v;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      bus.in_valid = 1'b0;
      bus.in_row = '0;
      clear_model();
      repeat (2) tick();
      reset = 1'b0;
      repeat (5) begin
         tick();
         check("rst_ready", 32'(bus.in_ready), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_prog", 32'(prog_wt), 0);
         check("rst_done", 32'(done), 0);
      end
      check_img("rst_img");
      check_sum("rst_csum");
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) rows[r][k*W +: W] = W'(r*N + k);
      full_load(0, 1'b0);
      for (int i = 0; i < N*N; i++) check("ident_img", 32'(wr_weight[i]), i);
`ifdef WT_LOAD_CHECKSUM_EN
      check("csum_120", 32'(wt_checksum), 120);
`endif
      full_load(1, 1'b0);
      fill_rows(8'hAA, 1'b0);
      full_load(0, 1'b0);
      start();
      send_row({N{8'h55}}, 0, 1'b0);
      send_row({N{8'h55}}, 0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_row = {N{8'h55}};
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_prog", 32'(prog_wt), 0);
      check("abort_ready", 32'(bus.in_ready), 0);
      tick();
      check("abort_prog2", 32'(prog_wt), 0);
      check("abort_done", 32'(done), 0);
      check_img("abort_img");
      check_sum("abort_csum");
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      check("idle_abort_busy", 32'(busy), 0);
      fill_rows('0, 1'b1);
      load_abort = 1'b1;
      start();
      load_abort = 1'b0;
      for (int r = 0; r < N; r++) send_row(rows[r], 0, 1'b0);
      load_abort = 1'b1;
      finish_check();
      load_abort = 1'b0;
      start();
      send_row(W*N'($urandom), 0, 1'b0);
      send_row(W*N'($urandom), 0, 1'b0);
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_row = $urandom;
      tick();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      clear_model();
      check("rstmid_prog", 32'(prog_wt), 0);
      check("rstmid_busy", 32'(busy), 0);
      check_img("rstmid_img");
      check_sum("rstmid_csum");
      tick();
      check("rstmid_done", 32'(done), 0);
      fill_rows('0, 1'b1);
      full_load(0, 1'b0);
      for (int it = 0; it < 8; it++) begin
         fill_rows('0, 1'b1);
         full_load(2, 1'b1);
      end
      fill_rows(8'hFF, 1'b0);
      full_load(0, 1'b0);
`ifdef WT_LOAD_CHECKSUM_EN
      check("csum_4080", 32'(wt_checksum), 4080);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
